// File: rtl/rv_pkg.sv
// Shared RV core constants and write-back helper types.
//   XLEN, REG_ADDR_W, REG_COUNT, ZERO_REG : register file geometry, shared with
//                                           the register file and the WB stage
//   wb_entry_t  : one queued mul/div result {waddr, wd}
//   wb_src_e    : which source owns the register file write port this cycle
//   reg_onehot  : destination address -> one-hot register mask
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_COUNT-1:0]  reg_mask_t;

    typedef struct packed {
        reg_addr_t waddr;
        xlen_t     wd;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FORCE,
        SRC_PIPE,
        SRC_FIFO
    } wb_src_e;

    function automatic reg_mask_t reg_onehot(input reg_addr_t a);
        reg_mask_t m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding mul/div results waiting for the register file port.
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_*    : enqueue {waddr, wd}; ignored when full
//   pop             : dequeue the head; ignored when empty
//   head_waddr/wd   : current head entry
//   count           : occupancy, 0..DEPTH
//   ent_valid       : per-slot valid bits (indexed by storage slot)
//   ent_waddr       : per-slot destination addresses, slot i at [i*5 +: 5]
module wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [REG_ADDR_W-1:0]         push_waddr,
    input  logic [XLEN-1:0]               push_wd,
    input  logic                          pop,
    output logic [REG_ADDR_W-1:0]         head_waddr,
    output logic [XLEN-1:0]               head_wd,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH*REG_ADDR_W-1:0]   ent_waddr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_entry_t        mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_pop  = pop  && (cnt_q != '0);
    assign do_push = push && (cnt_q != FULL);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (do_pop) begin
            valid_d[rd_q] = 1'b0;
            rd_d          = rd_q + 1'b1;
        end
        if (do_push) begin
            valid_d[wr_q] = 1'b1;
            wr_d          = wr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= '{waddr: push_waddr, wd: push_wd};
        end
    end

    always_comb begin
        ent_waddr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_waddr[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i].waddr;
        end
    end

    assign head_waddr = mem_q[rd_q].waddr;
    assign head_wd    = mem_q[rd_q].wd;
    assign count      = cnt_q;
    assign ent_valid  = valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file write port.
// Merges the single-cycle pipeline WB stream with buffered mul/div results.
//   clk, rst            : clock, asynchronous active-high reset
//   pipe_we/waddr/wd    : pipeline WB request (x0 writes are dropped)
//   pipe_stall          : pipeline write not taken this cycle
//   md_valid/waddr/wd   : mul/div result; md_ready when the FIFO has room
//   rf_we/waddr/wd      : registered register file write port
//   busy_mask           : registers with a pending mul/div write
//   fifo_count          : current FIFO occupancy
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pipe_we,
    input  logic [REG_ADDR_W-1:0]       pipe_waddr,
    input  logic [XLEN-1:0]             pipe_wd,
    output logic                        pipe_stall,
    input  logic                        md_valid,
    output logic                        md_ready,
    input  logic [REG_ADDR_W-1:0]       md_waddr,
    input  logic [XLEN-1:0]             md_wd,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_waddr,
    output logic [XLEN-1:0]             rf_wd,
    output logic [REG_COUNT-1:0]        busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned SW    = $clog2(STARVE_LIMIT+1);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

    logic                        pipe_real;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    wb_src_e                     src;

    logic [REG_ADDR_W-1:0]       head_waddr;
    logic [XLEN-1:0]             head_wd;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH*REG_ADDR_W-1:0] ent_waddr;

    logic [SW-1:0]               starve_q, starve_d;
    logic                        rf_we_q, rf_we_d;
    logic                        rf_md_q, rf_md_d;
    logic [REG_ADDR_W-1:0]       rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]             rf_wd_q, rf_wd_d;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_waddr (md_waddr),
        .push_wd    (md_wd),
        .pop        (pop),
        .head_waddr (head_waddr),
        .head_wd    (head_wd),
        .count      (fifo_count),
        .ent_valid  (ent_valid),
        .ent_waddr  (ent_waddr)
    );

    assign pipe_real  = pipe_we && (pipe_waddr != ZERO_REG);
    assign fifo_empty = (fifo_count == '0);

    // Ready looks at the registered count only: a full FIFO refuses even when
    // it is popping in the same cycle.
    assign md_ready = !rst && (fifo_count < FULL);

    // x0 results complete the handshake but are never queued.
    assign push = md_valid && md_ready && (md_waddr != ZERO_REG);

    always_comb begin
        src = SRC_NONE;
        if ((starve_q == STARVE_MAX) && !fifo_empty) begin
            src = SRC_FORCE;
        end else if (pipe_real) begin
            src = SRC_PIPE;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end
    end

    assign pop = (src == SRC_FORCE) || (src == SRC_FIFO);

    // Depends only on registered state so the pipeline sees it early.
    assign pipe_stall = (src == SRC_FORCE);

    always_comb begin
        rf_we_d    = 1'b0;
        rf_md_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wd_d    = rf_wd_q;
        case (src)
            SRC_PIPE: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = pipe_waddr;
                rf_wd_d    = pipe_wd;
            end
            SRC_FORCE, SRC_FIFO: begin
                rf_we_d    = 1'b1;
                rf_md_d    = 1'b1;
                rf_waddr_d = head_waddr;
                rf_wd_d    = head_wd;
            end
            default: ;
        endcase
    end

    // Counts cycles a non-empty FIFO loses to the pipe.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if ((src == SRC_PIPE) && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_md_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wd_q    <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_md_q    <= rf_md_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    // The register being written by an md pop stays busy until that write
    // has left the output register.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy_mask = busy_mask | reg_onehot(ent_waddr[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
        if (rf_we_q && rf_md_q) begin
            busy_mask = busy_mask | reg_onehot(rf_waddr_q);
        end
        busy_mask[0] = 1'b0;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wd    = rf_wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STARVE = 8;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wd;
    logic        pipe_stall;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wd;
    logic [31:0] busy_mask;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wd    (pipe_wd),
        .pipe_stall (pipe_stall),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_waddr   (md_waddr),
        .md_wd      (md_wd),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wd      (rf_wd),
        .busy_mask  (busy_mask),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending md results plus the last write.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_starve;
    logic        m_we, m_md;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_we     = 1'b0;
        m_md     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        if (m_we && m_md) m[m_wa] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Applies the arbitration rules to the inputs seen at this posedge.
    task automatic model_edge();
        bit   preal, nonempty, forced, accept;
        ent_t e;
        preal    = pipe_we && (pipe_waddr != 5'd0);
        nonempty = (mq.size() != 0);
        forced   = (m_starve == STARVE) && nonempty;
        accept   = md_valid && (mq.size() < DEPTH);
        if (forced || (!preal && nonempty)) begin
            e = mq.pop_front();
            m_we = 1'b1; m_md = 1'b1; m_wa = e.a; m_wd = e.d;
            m_starve = 0;
        end else if (preal) begin
            m_we = 1'b1; m_md = 1'b0; m_wa = pipe_waddr; m_wd = pipe_wd;
            m_starve = nonempty ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
        end else begin
            m_we = 1'b0; m_md = 1'b0;
            m_starve = 0;
        end
        if (accept && (md_waddr != 5'd0)) mq.push_back('{a: md_waddr, d: md_wd});
    endtask

    task automatic check_all();
        chk("rf_we",      {31'd0, rf_we},      {31'd0, m_we});
        chk("rf_waddr",   {27'd0, rf_waddr},   {27'd0, m_wa});
        chk("rf_wd",      rf_wd,               m_wd);
        chk("md_ready",   {31'd0, md_ready},   {31'd0, mq.size() < DEPTH});
        chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, (m_starve == STARVE) && (mq.size() != 0)});
        chk("busy_mask",  busy_mask,           exp_mask());
        chk("fifo_count", 32'(fifo_count),     mq.size());
    endtask

    // Called just after a negedge: check, drive, clock, update model.
    task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] mdd);
        check_all();
        pipe_we = pwe; pipe_waddr = pa; pipe_wd = pd;
        md_valid = mv; md_waddr = ma; md_wd = mdd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic reset_mid(input string tag);
        check_all();
        pipe_we = 1'b0; md_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_mask"},  busy_mask, 32'd0);
        chk({tag, "_we"},    {31'd0, rf_we}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, md_ready}, 32'd0);
        chk({tag, "_stall"}, {31'd0, pipe_stall}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    int unsigned stall_at;
    int unsigned p_pipe, p_md;

    initial begin
        rst = 1'b1;
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wd = '0;
        md_valid = 1'b0; md_waddr = '0; md_wd = '0;
        model_reset();
        #1;
        chk("rst_we",    {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wd",    rf_wd, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_mask",  busy_mask, 32'd0);
        chk("rst_rdy",   {31'd0, md_ready}, 32'd0);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain pipe write.
        step(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        chk("t1_we", {31'd0, rf_we}, 32'd1);
        chk("t1_wa", {27'd0, rf_waddr}, 32'd5);
        chk("t1_wd", rf_wd, 32'h0000_1234);
        chk("t1_mask", busy_mask, 32'd0);
        idle();

        // Single md result through an idle pipe.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        chk("t2_mask_n", {31'd0, busy_mask[7]}, 32'd1);
        chk("t2_we_n", {31'd0, rf_we}, 32'd0);
        idle();
        chk("t2_we_n1", {31'd0, rf_we}, 32'd1);
        chk("t2_wa_n1", {27'd0, rf_waddr}, 32'd7);
        chk("t2_wd_n1", rf_wd, 32'hDEAD_BEEF);
        chk("t2_mask_n1", {31'd0, busy_mask[7]}, 32'd1);
        idle();
        chk("t2_mask_n2", {31'd0, busy_mask[7]}, 32'd0);

        // Fill the FIFO behind continuous pipe writes until starvation forces a pop.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'd9, 32'h900 + 32'(i), 1'b1, 5'(i), 32'h1000 + 32'(i));
        chk("t3_count", 32'(fifo_count), 32'd4);
        chk("t3_rdy", {31'd0, md_ready}, 32'd0);
        stall_at = 99;
        for (int i = 0; i < 20; i++) begin
            if (pipe_stall) begin
                stall_at = i;
                break;
            end
            step(1'b1, 5'd9, 32'h2000 + 32'(i), 1'b0, 5'd0, 32'd0);
        end
        chk("t3_stall_at", stall_at, 32'd5);
        step(1'b1, 5'd9, 32'h3000, 1'b0, 5'd0, 32'd0);
        chk("t3_pop_wa", {27'd0, rf_waddr}, 32'd1);
        chk("t3_pop_wd", rf_wd, 32'h1001);
        chk("t3_count3", 32'(fifo_count), 32'd3);
        chk("t3_rdy3", {31'd0, md_ready}, 32'd1);
        chk("t3_stall0", {31'd0, pipe_stall}, 32'd0);
        repeat (4) idle();

        // x0 writes from both sources.
        step(1'b1, 5'd0, 32'hAAAA_0000, 1'b1, 5'd0, 32'hBBBB_0000);
        chk("t4_we", {31'd0, rf_we}, 32'd0);
        chk("t4_count", 32'(fifo_count), 32'd0);
        chk("t4_mask0", {31'd0, busy_mask[0]}, 32'd0);

        // Push and pop in the same cycle at count 2.
        step(1'b1, 5'd20, 32'h20, 1'b1, 5'd10, 32'hA0);
        step(1'b1, 5'd21, 32'h21, 1'b1, 5'd11, 32'hA1);
        chk("t5_count2", 32'(fifo_count), 32'd2);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hA2);
        chk("t5_count_pp", 32'(fifo_count), 32'd2);
        chk("t5_pop0", {27'd0, rf_waddr}, 32'd10);
        idle();
        chk("t5_pop1", {27'd0, rf_waddr}, 32'd11);
        idle();
        chk("t5_pop2", {27'd0, rf_waddr}, 32'd12);
        idle();

        // Asynchronous reset with three queued entries.
        for (int i = 1; i <= 3; i++)
            step(1'b1, 5'd30, 32'h30 + 32'(i), 1'b1, 5'(i), 32'h40 + 32'(i));
        reset_mid("t6");
        idle();
        chk("t6_nostale", {31'd0, rf_we}, 32'd0);
        idle();

        // Random traffic in phases of varying pipe / md pressure.
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) begin
                p_pipe = $urandom_range(20, 100);
                p_md   = $urandom_range(10, 90);
            end
            if (c == 400) reset_mid("rnd");
            step($urandom_range(0, 99) < p_pipe, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < p_md,   5'($urandom_range(0, 31)), $urandom);
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter driving the write port of the register file. It merges the single-cycle pipeline WB stream with out-of-order results from the multi-cycle mul/div unit. Mul/div results are buffered in a small FIFO, and the block exports a busy mask for the hazard unit. All outputs are registered on posedge, so they are stable when the register file samples on negedge.

## Interface
- DEPTH, 4: mul/div result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8: consecutive lost arbitration cycles before FIFO is forced to win; ≥1
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- pipe_we  in  1  pipeline WB write request
- pipe_waddr  in  5  pipeline destination register
- pipe_wd  in  32  pipeline write data
- pipe_stall  out  1  pipeline write not taken this cycle; pipeline holds its WB request
- md_valid  in  1  mul/div result valid
- md_ready  out  1  FIFO can accept a result
- md_waddr  in  5  mul/div destination register
- md_wd  in  32  mul/div result
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wd  out  32  register file write data
- busy_mask  out  32  bit r set while a mul/div write to xr is pending
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Pipe request is real only if pipe_we=1 and pipe_waddr≠0. Writes to x0 are silently dropped, because the register file does not hardwire x0.
- md handshake:
  - Accept when md_valid && md_ready.
  - md_ready = !rst && fifo_count<DEPTH. It depends on registered count only, so a full FIFO does not accept even in a pop cycle.
  - Accepted md results with md_waddr=0 are consumed but not enqueued.
- Arbitration per cycle, in priority order:
  - (1) starve_cnt==STARVE_LIMIT and FIFO non-empty: pop FIFO head to rf_*, pipe_stall=1, pipe request not taken.
  - (2) real pipe request: pipe data to rf_*.
  - (3) FIFO non-empty: pop head.
  - (4) otherwise rf_we=0, rf_waddr/rf_wd hold their last value.
- starve_cnt:
  - +1 on cycles where the FIFO is non-empty and the pipe wins.
  - Cleared on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- pipe_stall is combinational from registered state. It is 0 whenever the FIFO is empty.
- Simultaneous push and pop: both occur; count unchanged.
- busy_mask = OR of one-hot(waddr) over valid FIFO entries, plus one-hot(rf_waddr) when rf_we=1 from an md pop. Bit 0 is always 0. Duplicate addresses are allowed; a bit clears only when no source remains.
- WAW ordering between pipe and queued md writes is the hazard unit's job, using busy_mask. This block writes in arbitration order and does no comparison.

## Timing
- Reset values (immediate, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wd=0.
  - FIFO empty, fifo_count=0, busy_mask=0, starve_cnt=0.
  - pipe_stall=0, md_ready=0 while rst is high.
- Pipe latency: request sampled at posedge N → rf_* valid after N, written to the register file at the following negedge.
- md latency:
  - Accepted at posedge N → earliest rf_we at posedge N+1 (empty FIFO, no pipe request).
  - busy_mask bit rises after N and falls after the posedge following the pop.
- Reset asserted mid-operation: queued md results are discarded, no rf write is issued, and the mask clears immediately.
- First posedge after rst deasserts: md_ready=1, normal arbitration.

## Structure
- Shared package rv_pkg holds XLEN=32, REG_ADDR_W=5, REG_COUNT=32 and ZERO_REG=5'd0. The register file and WB stage use the same constants.
- One sub-module, wb_fifo:
  - Synchronous FIFO, DEPTH entries of {waddr, wd}, with push/pop/count.
  - Exposes per-entry valid and waddr for mask generation.
  - Pointer wrap via power-of-two indexing.
- Top level holds the arbitration, starve counter, mask OR-tree and output register.

## Test plan
- Pipe write x5=0x00001234, no md traffic → rf_we=1, rf_waddr=5, rf_wd=0x1234 after the next posedge; busy_mask=0.
- md x7=0xDEADBEEF accepted at edge N, idle pipe → busy_mask[7]=1 after N; rf write of x7 after N+1; busy_mask[7]=0 after N+2.
- Four md pushes (x1..x4) with continuous pipe writes → md_ready=0 at count 4. After 8 lost cycles pipe_stall=1 for one cycle and x1 is popped; starve_cnt clears, and the cycle after the pop md_ready=1 (count 3).
- Pipe write to x0 and md result to x0 → no rf_we, md accepted, count unchanged, busy_mask[0]=0.
- Push and pop in the same cycle at count 2 → count stays 2, FIFO order preserved (pops in push order).
- Async rst mid-stream with 3 queued entries → immediately count=0, busy_mask=0, rf_we=0. No stale write after release.
